// File: rtl/tx_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tx_dma_scheduler
// Brief  : Round-robin descriptor scheduler feeding a single TX SRAM engine.
// Rev    : 1.0  initial release
// ============================================================================
module tx_dma_scheduler #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sched_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_base,
    input  logic [NREQ*32-1:0]   req_size,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 eng_start_tx,
    output logic [31:0]          eng_base,
    output logic [31:0]          eng_size,
    input  logic                 eng_tx_ready,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int               c_CW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_pend;
    logic [31:0]       r_base_q [NREQ];
    logic [31:0]       r_size_q [NREQ];
    logic [2:0]        r_rr_ptr;
    logic [c_CW-1:0]   r_cnt;
    logic [NREQ-1:0]   r_done;
    logic [NREQ-1:0]   r_err;
    logic              r_eng_start;
    logic [31:0]       r_eng_base;
    logic [31:0]       r_eng_size;
    logic              r_busy;
    logic [2:0]        r_grant_id;

    logic [NREQ-1:0]   w_capture;
    logic              w_hi_found;
    logic [2:0]        w_hi_idx;
    logic [2:0]        w_lo_idx;
    logic [2:0]        w_sel;
    logic [31:0]       w_sel_base;
    logic [31:0]       w_sel_size;
    logic              w_grant_go;
    logic              w_fin;
    logic              w_fin_err;
    logic [2:0]        w_fin_idx;
    logic [2:0]        w_fin_next;
    logic [NREQ-1:0]   w_done_vec;
    logic [NREQ-1:0]   w_err_vec;

    assign w_capture = req_valid & ~r_pend;
    assign w_grant_go = (r_state == S_IDLE) && sched_en && eng_tx_ready && (|r_pend);

    // First pending slot at or above rr_ptr wins; otherwise wrap to the lowest pending slot.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = 3'd0;
        w_lo_idx   = 3'd0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (r_pend[j]) begin
                w_lo_idx = 3'(j);
                if (3'(j) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(j);
                end
            end
        end
        w_sel      = w_hi_found ? w_hi_idx : w_lo_idx;
        w_sel_base = 32'd0;
        w_sel_size = 32'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) == w_sel) begin
                w_sel_base = r_base_q[j];
                w_sel_size = r_size_q[j];
            end
        end
    end

    always_comb begin
        w_fin     = 1'b0;
        w_fin_err = 1'b0;
        w_fin_idx = r_grant_id;
        case (r_state)
            S_IDLE: begin
                if (w_grant_go && (w_sel_size == 32'd0)) begin
                    w_fin     = 1'b1;
                    w_fin_idx = w_sel;
                end
            end
            S_WAIT_BUSY: begin
                if (eng_tx_ready && (r_cnt == c_CNT_LAST)) begin
                    w_fin     = 1'b1;
                    w_fin_err = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (eng_tx_ready) begin
                    w_fin = 1'b1;
                end
            end
            default: ;
        endcase
        w_done_vec = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_fin && (3'(j) == w_fin_idx)) begin
                w_done_vec[j] = 1'b1;
            end
        end
        w_err_vec  = w_fin_err ? w_done_vec : '0;
        w_fin_next = (w_fin_idx == 3'(NREQ - 1)) ? 3'd0 : w_fin_idx + 3'd1;
    end

    // A slot cannot be refilled on its completion edge: capture is gated by the old pend.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            for (int j = 0; j < NREQ; j++) begin
                r_base_q[j] <= 32'd0;
                r_size_q[j] <= 32'd0;
            end
        end else begin
            r_pend <= (r_pend & ~w_done_vec) | w_capture;
            for (int j = 0; j < NREQ; j++) begin
                if (w_capture[j]) begin
                    r_base_q[j] <= req_base[32*j +: 32];
                    r_size_q[j] <= req_size[32*j +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 3'd0;
            r_cnt       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_eng_start <= 1'b0;
            r_eng_base  <= 32'd0;
            r_eng_size  <= 32'd0;
            r_busy      <= 1'b0;
            r_grant_id  <= 3'd0;
        end else begin
            r_done <= w_done_vec;
            r_err  <= w_err_vec;
            if (w_fin) begin
                r_rr_ptr <= w_fin_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_grant_go) begin
                        r_grant_id <= w_sel;
                        if (w_sel_size != 32'd0) begin
                            r_eng_base  <= w_sel_base;
                            r_eng_size  <= w_sel_size;
                            r_eng_start <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_START;
                        end
                    end
                end
                S_START: begin
                    r_eng_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!eng_tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (eng_tx_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = ~r_pend;
    assign req_done     = r_done;
    assign req_err      = r_err;
    assign eng_start_tx = r_eng_start;
    assign eng_base     = r_eng_base;
    assign eng_size     = r_eng_size;
    assign busy         = r_busy;
    assign grant_id     = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_tx_dma_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_tx_dma_scheduler
// Brief  : Scoreboard bench for tx_dma_scheduler with a simple engine model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tx_dma_scheduler;

    logic          clk = 1'b0;
    logic          reset;
    logic          sched_en;
    logic [3:0]    req_valid;
    logic [127:0]  req_base;
    logic [127:0]  req_size;
    logic [3:0]    req_ready;
    logic [3:0]    req_done;
    logic [3:0]    req_err;
    logic          eng_start_tx;
    logic [31:0]   eng_base;
    logic [31:0]   eng_size;
    logic          eng_tx_ready;
    logic          busy;
    logic [2:0]    grant_id;

    tx_dma_scheduler #(.NREQ(4), .BUSY_TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sched_en     (sched_en),
        .req_valid    (req_valid),
        .req_base     (req_base),
        .req_size     (req_size),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .eng_start_tx (eng_start_tx),
        .eng_base     (eng_base),
        .eng_size     (eng_size),
        .eng_tx_ready (eng_tx_ready),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] base; logic [31:0] size; int gid; int lat; } start_exp_t;
    typedef struct { int idx; bit err; int lat_ref; int lat_start; } done_exp_t;

    start_exp_t q_start[$];
    done_exp_t  q_done[$];
    int cyc = 0;
    int t_ref = 0;
    int last_start = 0;
    int errors = 0;
    int checks = 0;
    int busy_len = 4;
    int ignore_starts = 0;
    int eng_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Engine model: drops tx_ready for busy_len cycles after each start, unless told to stall.
    always @(negedge clk) begin
        if (reset) begin
            eng_tx_ready = 1'b1;
            eng_cnt      = 0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) eng_tx_ready = 1'b1;
        end else if (eng_start_tx) begin
            if (ignore_starts > 0) begin
                ignore_starts--;
            end else begin
                eng_tx_ready = 1'b0;
                eng_cnt      = busy_len;
            end
        end
    end

    start_exp_t s;
    done_exp_t  d;
    always @(negedge clk) begin
        if (!reset) begin
            if (eng_start_tx) begin
                last_start = cyc;
                if (q_start.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: base=0x%0h size=%0d gid=%0d, none expected",
                             eng_base, eng_size, grant_id);
                end else begin
                    s = q_start.pop_front();
                    chk("start_base", eng_base, s.base);
                    chk("start_size", eng_size, s.size);
                    chk("start_gid", grant_id, s.gid);
                    if (s.lat >= 0) chk("start_latency", cyc - t_ref, s.lat);
                end
            end
            if (req_done != 4'd0 || req_err != 4'd0) begin
                if (q_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=%b err=%b, none expected", req_done, req_err);
                end else begin
                    d = q_done.pop_front();
                    chk("done_vec", req_done, 64'(4'b0001 << d.idx));
                    chk("err_vec", req_err, d.err ? 64'(4'b0001 << d.idx) : 64'd0);
                    chk("done_gid", grant_id, d.idx);
                    if (d.lat_ref >= 0)   chk("done_latency_ref", cyc - t_ref, d.lat_ref);
                    if (d.lat_start >= 0) chk("done_latency_start", cyc - last_start, d.lat_start);
                end
            end
        end
    end

    task automatic set_desc(input int i, input logic [31:0] b, input logic [31:0] sz);
        req_base[32*i +: 32] = b;
        req_size[32*i +: 32] = sz;
    endtask

    task automatic pulse_valid(input logic [3:0] m);
        @(negedge clk);
        req_valid = m;
        @(negedge clk);
        t_ref     = cyc;
        req_valid = 4'd0;
    endtask

    task automatic exp_job(input int i, input logic [31:0] b, input logic [31:0] sz);
        q_start.push_back('{base: b, size: sz, gid: i, lat: -1});
        q_done.push_back('{idx: i, err: 1'b0, lat_ref: -1, lat_start: -1});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((q_start.size() != 0 || q_done.size() != 0 || busy || req_ready != 4'hf) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget), 1);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_start_tx && n < 50);
        chk(name, eng_start_tx, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_start"}, eng_start_tx, 0);
        chk({tag, "_base"},  eng_base, 0);
        chk({tag, "_size"},  eng_size, 0);
        chk({tag, "_done"},  req_done, 0);
        chk({tag, "_err"},   req_err, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_gid"},   grant_id, 0);
        chk({tag, "_ready"}, req_ready, 4'hf);
    endtask

    initial begin
        reset = 1'b1; sched_en = 1'b1; req_valid = 4'd0; req_base = '0; req_size = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Single job
        set_desc(0, 32'h100, 32'd4);
        exp_job(0, 32'h100, 32'd4);
        pulse_valid(4'b0001);
        wait_drain("drain_single", 100);

        // Contention from a fresh reset so rr_ptr starts at 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_desc(i, 32'h1000 * (i + 1), 32'(i + 2));
            exp_job(i, 32'h1000 * (i + 1), 32'(i + 2));
        end
        pulse_valid(4'b1111);
        wait_drain("drain_contention", 300);
        set_desc(0, 32'h5000, 32'd8);
        set_desc(2, 32'h7000, 32'd9);
        exp_job(0, 32'h5000, 32'd8);
        exp_job(2, 32'h7000, 32'd9);
        pulse_valid(4'b0101);
        wait_drain("drain_rerequest", 200);

        // Zero size: done one cycle after the grant cycle, no engine start
        set_desc(1, 32'h900, 32'd0);
        q_done.push_back('{idx: 1, err: 1'b0, lat_ref: 1, lat_start: -1});
        pulse_valid(4'b0010);
        wait_drain("drain_zero", 50);

        // Timeout on req2 (START cycle + 16 WAIT_BUSY cycles), then req3 runs normally
        ignore_starts = 1;
        set_desc(2, 32'h2200, 32'd5);
        set_desc(3, 32'h3300, 32'd6);
        q_start.push_back('{base: 32'h2200, size: 32'd5, gid: 2, lat: -1});
        q_start.push_back('{base: 32'h3300, size: 32'd6, gid: 3, lat: -1});
        q_done.push_back('{idx: 2, err: 1'b1, lat_ref: -1, lat_start: 17});
        q_done.push_back('{idx: 3, err: 1'b0, lat_ref: -1, lat_start: -1});
        pulse_valid(4'b1100);
        wait_drain("drain_timeout", 300);

        // sched_en gating and mid-job deassertion
        sched_en = 1'b0;
        set_desc(3, 32'h5550, 32'd3);
        pulse_valid(4'b1000);
        repeat (8) @(negedge clk);
        chk("gated_busy", busy, 0);
        chk("gated_ready", req_ready, 4'b0111);
        q_start.push_back('{base: 32'h5550, size: 32'd3, gid: 3, lat: 1});
        q_done.push_back('{idx: 3, err: 1'b0, lat_ref: -1, lat_start: -1});
        t_ref    = cyc;
        sched_en = 1'b1;
        wait_start("sched_start_seen");
        sched_en = 1'b0;
        wait_drain("drain_sched", 100);
        sched_en = 1'b1;

        // Reset while the engine is busy (WAIT_DONE)
        busy_len = 20;
        set_desc(0, 32'h4440, 32'd7);
        q_start.push_back('{base: 32'h4440, size: 32'd7, gid: 0, lat: -1});
        pulse_valid(4'b0001);
        wait_start("midreset_start_seen");
        repeat (2) @(negedge clk);
        chk("midreset_busy", busy, 1);
        chk("midreset_engine_busy", eng_tx_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        reset    = 1'b0;
        busy_len = 4;
        repeat (30) @(negedge clk);
        chk("final_start_queue", q_start.size(), 0);
        chk("final_done_queue", q_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tx_dma_scheduler.md
TX_DMA_SCHEDULER -- requirements
Module: tx_dma_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16, the maximum number of cycles to wait for the engine to drop eng_tx_ready after a start.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port sched_en  in  1  high permits new grants; low blocks new grants but lets the in-flight job finish.
REQ-006 Port req_valid  in  NREQ  per-requester descriptor valid.
REQ-007 Port req_base  in  NREQ*32  per-requester byte base address; slice i is [32*i+31:32*i].
REQ-008 Port req_size  in  NREQ*32  per-requester word count; slice i is [32*i+31:32*i].
REQ-009 Port req_ready  out  NREQ  combinational; bit i = !pend[i].
REQ-010 Port req_done  out  NREQ  registered; one-cycle completion pulse per requester.
REQ-011 Port req_err  out  NREQ  registered; one-cycle pulse, coincident with req_done, flagging a timeout.
REQ-012 Port eng_start_tx  out  1  registered start pulse to the TX SRAM engine.
REQ-013 Port eng_base  out  32  registered base address to the engine.
REQ-014 Port eng_size  out  32  registered word count to the engine.
REQ-015 Port eng_tx_ready  in  1  engine idle indication.
REQ-016 Port busy  out  1  registered; high whenever state != IDLE.
REQ-017 Port grant_id  out  3  registered; index of the current or last granted requester.

Function
REQ-018 Each requester SHALL own a 1-deep descriptor slot: pend[i], base_q[i], size_q[i].
REQ-019 When req_valid[i] && !pend[i], the block SHALL capture base/size and set pend[i] on that edge.
REQ-020 pend[i] SHALL clear on the edge that pulses req_done[i]; req_ready[i] rises the following cycle, and no same-cycle refill is allowed.
REQ-021 The FSM SHALL have states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-022 IDLE: if sched_en && eng_tx_ready && any pend, the block SHALL select the first pending index searching upward from rr_ptr with wrap, and load grant_id.
REQ-023 IDLE, selected size_q == 0: the block SHALL pulse req_done on the next edge, clear pend, set rr_ptr = idx+1 mod NREQ, never start the engine, and remain in IDLE.
REQ-024 IDLE, selected size_q != 0: the block SHALL load eng_base/eng_size from the slot and go to START.
REQ-025 START: eng_start_tx SHALL be high for exactly this one cycle, then the FSM goes to WAIT_BUSY with the timeout counter cleared.
REQ-026 WAIT_BUSY: when eng_tx_ready == 0 the FSM SHALL go to WAIT_DONE; otherwise the counter increments.
REQ-027 WAIT_BUSY: when the counter reaches BUSY_TIMEOUT-1 with eng_tx_ready still high, the block SHALL pulse req_done and req_err, clear pend, advance rr_ptr, and go to IDLE.
REQ-028 WAIT_DONE: when eng_tx_ready == 1 the block SHALL pulse req_done[grant_id], clear pend, set rr_ptr = grant_id+1 mod NREQ, and go to IDLE.
REQ-029 Arbitration SHALL be round-robin: the requester just served has lowest priority at the next grant.
REQ-030 The minimum spacing between consecutive engine starts SHALL be one IDLE cycle after a completion.
REQ-031 eng_base and eng_size SHALL hold stable from START until the next grant.
REQ-032 Descriptor writes to a slot that is pending SHALL be ignored, since req_ready is low.
REQ-033 sched_en deasserted during START, WAIT_BUSY or WAIT_DONE SHALL NOT abort the job.
REQ-034 req_done and req_err SHALL be one-hot or zero in any cycle.

Reset
REQ-035 On reset the block SHALL set: state=IDLE, pend=0, rr_ptr=0, counter=0.
REQ-036 On reset the block SHALL drive: eng_start_tx=0, eng_base=0, eng_size=0, req_done=0, req_err=0, busy=0, grant_id=0.
REQ-037 Reset mid-job SHALL discard all descriptors without any done pulse, and take priority over every other event in the same cycle.

Verification
REQ-038 Single job: req0 base=0x100, size=4 with an engine model -> one eng_start_tx pulse; eng_base=0x100, eng_size=4; req_done[0] pulses once the model returns tx_ready=1.
REQ-039 Contention: req0..req3 all valid in the same cycle -> grants in order 0,1,2,3; then req0 and req2 re-requested -> order 0,2.
REQ-040 Zero size: req1 size=0 -> req_done[1] pulses on the cycle after the grant; eng_start_tx never asserts.
REQ-041 Timeout: model holds tx_ready=1 after start, BUSY_TIMEOUT=16 -> req_done[2] and req_err[2] pulse 16 cycles after START; next grant proceeds.
REQ-042 sched_en: sched_en=0 with req3 pending -> no start; sched_en=1 -> start on the next IDLE cycle; sched_en dropped mid-job -> job still completes.
REQ-043 Reset mid-job: reset asserted in WAIT_DONE -> all outputs zero on the next cycle, req_ready all high, no req_done pulse.
